tb_timebase_sync: RTL and testbench
===================================

// Module: tb_timebase_sync
//
// PURPOSE
// Testbench timebase for the manycore cosim top: a free-running global cycle counter for profilers and tracing,
// plus a fixed-depth register delay chain that re-times the fabric's tag-programming-done flag.
// It also derives the host-endpoint reset, which is held until the delayed done flag arrives.
// It sits in the core clock domain beside the testbench and feeds the DPI host endpoint and the profilers.
//
// PARAMETERS
// width_p       64  global counter width in bits (>=1)
// num_stages_p  3   delay-chain depth in cycles; 0 = combinational passthrough
// data_width_p  1   width of the delayed bus (bit 0 carries reset_done)
//
// PORTS
// clk_i           in   1             core clock
// reset_i         in   1             synchronous active-high reset
// data_i          in   data_width_p  chain input (bit 0 = tag/reset done from the fabric)
// data_o          out  data_width_p  data_i delayed num_stages_p cycles
// host_reset_o    out  1             reset_i | ~data_o[0]; drives the host endpoint reset
// snap_v_i        in   1             capture request for a counter snapshot
// snap_r_o        out  width_p       last captured counter value
// snap_v_o        out  1             one-cycle pulse: snap_r_o updated this cycle
// ctr_r_o         out  width_p       global cycle count (registered)
//
// BEHAVIOUR
// - Single clock domain. All state updates on the posedge of clk_i only. No latches.
// - Reset is synchronous. While reset_i=1 at an edge, the following are cleared to 0 after that edge:
//   ctr_r_o, every chain stage (so data_o=0), snap_r_o and snap_v_o.
// - host_reset_o is combinational, equal to reset_i | ~data_o[0]. It is 1 throughout reset.
// - Counter:
//   - ctr_r_o <= ctr_r_o + 1 on every edge with reset_i=0. It runs unconditionally; there is no enable.
//   - The first edge after reset deassertion yields ctr_r_o=1.
//   - Arithmetic is modulo 2^width_p: all-ones wraps to 0 with no flag and no stall.
// - Delay chain:
//   - stage[0] <= data_i; stage[k] <= stage[k-1]; data_o = stage[num_stages_p-1].
//   - Latency is exactly num_stages_p edges.
//   - When num_stages_p=0, data_o=data_i combinationally and the chain holds no state.
//   - Reset asserted mid-flight flushes every in-flight value to 0.
// - Snapshot:
//   - An edge with snap_v_i=1 and reset_i=0 sets snap_r_o <= ctr_r_o, which is the value before that
//     edge's increment. The same edge sets snap_v_o <= 1.
//   - Any other edge sets snap_v_o <= 0 and snap_r_o holds its value.
//   - Back-to-back requests capture consecutive values.
//   - When reset_i and snap_v_i are asserted together, reset wins.
// - No back-pressure and no handshake. Every input is sampled every cycle.
// - Reset dominates every other simultaneous event.
// - Implement the chain with a generate loop over num_stages_p.
// - Clock generation and the DPI access paths are outside this block. Counter and chain read-out happen
//   only through the ports listed above.
//
// TESTING
// 1. Hold reset_i 16 cycles -> ctr_r_o=0, data_o=0, host_reset_o=1, snap_v_o=0 throughout.
//    Release -> ctr_r_o reads 1,2,3,... on successive edges.
// 2. Default params: raise data_i[0] at the edge where ctr_r_o becomes 10.
//    -> data_o[0] rises exactly 3 edges later, at ctr_r_o=13. host_reset_o falls in the same cycle.
// 3. width_p=4: run 20 cycles after reset -> the sequence ...14,15,0,1... wraps with no glitch.
// 4. Pulse snap_v_i while ctr_r_o=42 -> next cycle snap_r_o=42 and snap_v_o=1. The following cycle
//    snap_v_o=0 and snap_r_o stays 42.
// 5. Reassert reset_i while data_i=1 and ctr_r_o=100 -> after the edge: ctr_r_o=0, data_o=0,
//    host_reset_o=1. After release, data_o returns 3 edges after the chain refills.
// 6. num_stages_p=0 -> data_o tracks data_i in the same cycle. Toggle data_i mid-cycle; data_o follows
//    with zero latency.

Source files
------------

// File: rtl/tb_timebase_sync.sv
// Cosim timebase: free-running global cycle counter with snapshot capture, plus a
// fixed-depth delay chain that re-times the fabric's reset-done flag into the host reset.
module tb_timebase_sync #(
  parameter int width_p      = 64,
  parameter int num_stages_p = 3,
  parameter int data_width_p = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [data_width_p-1:0] data_i,
  output logic [data_width_p-1:0] data_o,
  output logic                    host_reset_o,
  input  logic                    snap_v_i,
  output logic [width_p-1:0]      snap_r_o,
  output logic                    snap_v_o,
  output logic [width_p-1:0]      ctr_r_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctr_r_o <= '0;
    end else begin
      ctr_r_o <= ctr_r_o + width_p'(1);
    end
  end

  // Snapshot takes the counter value from before this edge's increment.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      snap_r_o <= '0;
      snap_v_o <= 1'b0;
    end else if (snap_v_i) begin
      snap_r_o <= ctr_r_o;
      snap_v_o <= 1'b1;
    end else begin
      snap_v_o <= 1'b0;
    end
  end

  generate
    if (num_stages_p == 0) begin : g_passthrough
      assign data_o = data_i;
    end else begin : g_chain
      logic [data_width_p-1:0] stage [num_stages_p];

      for (genvar k = 0; k < num_stages_p; k++) begin : g_stage
        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            stage[k] <= '0;
          end else if (k == 0) begin
            stage[k] <= data_i;
          end else begin
            stage[k] <= stage[(k == 0) ? 0 : k-1];
          end
        end
      end

      assign data_o = stage[num_stages_p-1];
    end
  endgenerate

  // Host endpoint stays in reset until the re-timed done flag arrives.
  assign host_reset_o = reset_i | ~data_o[0];

endmodule

// File: tb/tb_tb_timebase_sync.sv
// Randomized self-checking bench for tb_timebase_sync: default, 4-bit counter and
// zero-stage instances compared against an edge-history reference model.
module tb_tb_timebase_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:0]  data;
  logic        snap_v;

  logic [0:0]  data_out;
  logic        host_reset;
  logic [63:0] snap_r_out;
  logic        snap_v_out;
  logic [63:0] ctr;

  logic [0:0]  w4_data_out;
  logic        w4_host_reset;
  logic [3:0]  w4_snap_r;
  logic        w4_snap_v;
  logic [3:0]  w4_ctr;

  logic [0:0]  s0_data_out;
  logic        s0_host_reset;
  logic [63:0] s0_snap_r;
  logic        s0_snap_v;
  logic [63:0] s0_ctr;

  int total = 0;
  int bad   = 0;

  // Reference model: counts since reset, per-edge input history, snapshot registers.
  longint unsigned cnt;
  logic [63:0]     snap_r_exp;
  logic            snap_v_exp;
  bit              din_q[$];
  bit              rst_q[$];

  always #5 clk = ~clk;

  tb_timebase_sync dut (
    .clk_i(clk), .reset_i(reset), .data_i(data), .data_o(data_out),
    .host_reset_o(host_reset), .snap_v_i(snap_v), .snap_r_o(snap_r_out),
    .snap_v_o(snap_v_out), .ctr_r_o(ctr)
  );

  tb_timebase_sync #(.width_p(4)) dut_w4 (
    .clk_i(clk), .reset_i(reset), .data_i(data), .data_o(w4_data_out),
    .host_reset_o(w4_host_reset), .snap_v_i(snap_v), .snap_r_o(w4_snap_r),
    .snap_v_o(w4_snap_v), .ctr_r_o(w4_ctr)
  );

  tb_timebase_sync #(.num_stages_p(0)) dut_s0 (
    .clk_i(clk), .reset_i(reset), .data_i(data), .data_o(s0_data_out),
    .host_reset_o(s0_host_reset), .snap_v_i(snap_v), .snap_r_o(s0_snap_r),
    .snap_v_o(s0_snap_v), .ctr_r_o(s0_ctr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Delayed bit = input from three edges back, unless any reset hit within those edges.
  function automatic bit expData();
    int n = din_q.size();
    if (n < 3) return 1'b0;
    for (int k = n - 3; k < n; k++) if (rst_q[k]) return 1'b0;
    return din_q[n-3];
  endfunction

  task automatic checkAll();
    bit d_exp = expData();
    checkOutput("ctr", ctr, cnt);
    checkOutput("data_o", {63'b0, data_out}, {63'b0, d_exp});
    checkOutput("host_reset", {63'b0, host_reset}, {63'b0, (reset | ~d_exp)});
    checkOutput("snap_r", snap_r_out, snap_r_exp);
    checkOutput("snap_v", {63'b0, snap_v_out}, {63'b0, snap_v_exp});
    checkOutput("w4_ctr", {60'b0, w4_ctr}, cnt % 16);
    checkOutput("w4_data_o", {63'b0, w4_data_out}, {63'b0, d_exp});
    checkOutput("s0_ctr", s0_ctr, cnt);
  endtask

  task automatic applyStimulus(input bit r, input bit d, input bit s);
    @(negedge clk);
    reset  = r;
    data   = d;
    snap_v = s;
    #1;
    checkOutput("s0_data_o", {63'b0, s0_data_out}, {63'b0, d});
    checkOutput("s0_host_reset", {63'b0, s0_host_reset}, {63'b0, (r | ~d)});
    @(posedge clk);
    din_q.push_back(d);
    rst_q.push_back(r);
    if (r) begin
      cnt        = 0;
      snap_r_exp = '0;
      snap_v_exp = 1'b0;
    end else begin
      if (s) begin
        snap_r_exp = cnt;
        snap_v_exp = 1'b1;
      end else begin
        snap_v_exp = 1'b0;
      end
      cnt++;
    end
    #1;
    checkAll();
  endtask

  initial begin
    reset  = 1'b1;
    data   = '0;
    snap_v = 1'b0;
    cnt        = 0;
    snap_r_exp = '0;
    snap_v_exp = 1'b0;

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, i[0]);
    checkOutput("reset_host", {63'b0, host_reset}, 64'd1);

    while (cnt != 10) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("chain_latency", {63'b0, data_out}, (i == 3) ? 64'd1 : 64'd0);
    end
    checkOutput("chain_ctr13", ctr, 64'd13);
    checkOutput("chain_host_low", {63'b0, host_reset}, 64'd0);

    while (cnt != 42) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("snap42_r", snap_r_out, 64'd42);
    checkOutput("snap42_v", {63'b0, snap_v_out}, 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("snap42_hold", snap_r_out, 64'd42);
    checkOutput("snap42_v_low", {63'b0, snap_v_out}, 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("snap_b2b", snap_r_out, 64'd45);

    while (cnt != 100) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("midreset_ctr", ctr, 64'd0);
    checkOutput("midreset_data", {63'b0, data_out}, 64'd0);
    checkOutput("midreset_host", {63'b0, host_reset}, 64'd1);
    checkOutput("midreset_snap_v", {63'b0, snap_v_out}, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("refill", {63'b0, data_out}, (i == 3) ? 64'd1 : 64'd0);
    end

    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0);

    // Zero-stage instance must follow a mid-cycle toggle without waiting for an edge.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      data = ~data;
      #1;
      checkOutput("s0_toggle", {63'b0, s0_data_out}, {63'b0, data});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
